// File: rtl/sra32_pkg.sv
// Shared types and constants for the 32-bit arithmetic right shifter.
package sra32_pkg;

    localparam int SRA32_WIDTH   = 32;
    localparam int SRA32_SHAMT_W = 5;

    typedef logic [SRA32_WIDTH-1:0]   sra32_word_t;
    typedef logic [SRA32_SHAMT_W-1:0] sra32_shamt_t;

endpackage

// File: rtl/sra32_stage.sv
// One conditional shift-right-by-2^K stage of the barrel shifter.
// Vacated upper bits take fill_i (the operand sign bit).
module sra32_stage
    import sra32_pkg::*;
#(
    parameter int K = 0
) (
    input  sra32_word_t data_i,
    input  logic        en_i,
    input  logic        fill_i,
    output sra32_word_t data_o
);

    localparam int SH = 1 << K;

    // Ones in the top SH bit positions: the lanes vacated by this stage.
    localparam sra32_word_t FILL_MASK = ~({SRA32_WIDTH{1'b1}} >> SH);

    sra32_word_t shifted;

    // Logical shift, then OR in the sign lanes when filling with ones.
    always_comb begin
        shifted = data_i >> SH;
        if (fill_i) begin
            shifted = shifted | FILL_MASK;
        end
        data_o = en_i ? shifted : data_i;
    end

endmodule

// File: rtl/shift_right_arith_32bit.sv
// Registered 32-bit arithmetic right shifter (Z = X >>> Y, Y unsigned,
// saturating to sign fill for Y >= 32).
// Optional macro SRA32_PIPE_EN adds a register after the 1/2/4/8 stages,
// raising latency from 1 to 2 cycles.
module shift_right_arith_32bit
    import sra32_pkg::*;
#(
    parameter int WIDTH = SRA32_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic             out_valid
);

`ifdef SRA32_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // Any amount bit above bit 4 means the whole word shifts out.
    logic sat;
    assign sat = |Y[WIDTH-1:SRA32_SHAMT_W];

    sra32_word_t stg_out [SRA32_SHAMT_W];

    // Values feeding the final (shift-by-16) stage and the result mux.
    sra32_word_t s4_data;
    logic        s4_en;
    logic        s4_sign;
    logic        s4_sat;
    logic        s4_vld;

`ifdef SRA32_PIPE_EN
    sra32_word_t mid_data_d, mid_data_q;
    logic        mid_b4_d,   mid_b4_q;
    logic        mid_sign_d, mid_sign_q;
    logic        mid_sat_d,  mid_sat_q;

    // Capture the partial shift plus the bits the last stage still needs.
    always_comb begin
        mid_data_d = stg_out[3];
        mid_b4_d   = Y[4];
        mid_sign_d = X[WIDTH-1];
        mid_sat_d  = sat;
    end

    // Mid-pipe register, cleared by reset so in-flight work is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_data_q <= '0;
            mid_b4_q   <= 1'b0;
            mid_sign_q <= 1'b0;
            mid_sat_q  <= 1'b0;
        end else begin
            mid_data_q <= mid_data_d;
            mid_b4_q   <= mid_b4_d;
            mid_sign_q <= mid_sign_d;
            mid_sat_q  <= mid_sat_d;
        end
    end
`endif

    logic [LAT-1:0] vld_pipe_d, vld_pipe_q;

    // Select the last-stage source: mid register or straight combinational.
    always_comb begin
`ifdef SRA32_PIPE_EN
        s4_data = mid_data_q;
        s4_en   = mid_b4_q;
        s4_sign = mid_sign_q;
        s4_sat  = mid_sat_q;
        s4_vld  = vld_pipe_q[0];
`else
        s4_data = stg_out[3];
        s4_en   = Y[4];
        s4_sign = X[WIDTH-1];
        s4_sat  = sat;
        s4_vld  = in_valid;
`endif
    end

    // Stage chain: shifts of 1, 2, 4, 8 then 16, each filling with the sign.
    for (genvar k = 0; k < SRA32_SHAMT_W; k++) begin : g_stg
        sra32_word_t d_in;
        logic        en;
        logic        fill;
        if (k == 0) begin : g_first
            assign d_in = X;
            assign en   = Y[0];
            assign fill = X[WIDTH-1];
        end else if (k == SRA32_SHAMT_W - 1) begin : g_last
            assign d_in = s4_data;
            assign en   = s4_en;
            assign fill = s4_sign;
        end else begin : g_mid
            assign d_in = stg_out[k-1];
            assign en   = Y[k];
            assign fill = X[WIDTH-1];
        end
        sra32_stage #(.K(k)) u_stage (
            .data_i (d_in),
            .en_i   (en),
            .fill_i (fill),
            .data_o (stg_out[k])
        );
    end

    sra32_word_t z_d, z_q;

    // Output register loads only on a valid op; otherwise holds its value.
    always_comb begin
        z_d = z_q;
        if (s4_vld) begin
            z_d = s4_sat ? {SRA32_WIDTH{s4_sign}} : stg_out[SRA32_SHAMT_W-1];
        end
    end

    // Valid shift register tracking in_valid through the pipeline.
    always_comb begin
`ifdef SRA32_PIPE_EN
        vld_pipe_d = {vld_pipe_q[0], in_valid};
`else
        vld_pipe_d = in_valid;
`endif
    end

    // Output and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q        <= '0;
            vld_pipe_q <= '0;
        end else begin
            z_q        <= z_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign Z         = z_q;
    assign out_valid = vld_pipe_q[LAT-1];

endmodule

// File: tb/tb_shift_right_arith_32bit.sv
// Scoreboard bench for shift_right_arith_32bit: the driver queues expected
// results, an independent monitor checks them as out_valid presents them.
module tb_shift_right_arith_32bit;

`ifdef SRA32_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] X;
    logic [31:0] Y;
    logic [31:0] Z;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_z = '0;

    shift_right_arith_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_sra(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        if (y >= 32) r = {32{x[31]}};
        else         r = 32'($signed(x) >>> y[4:0]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp);
        @(negedge clk);
        in_valid = v;
        X = x;
        Y = y;
        if (v) exp_q.push_back(exp);
    endtask

    // Monitor: out_valid must follow in_valid by LAT edges; Z must match the
    // queued result when valid and hold the last result otherwise.
    initial begin
        logic [1:0] hist;
        logic       v;
        hist = '0;
        forever begin
            @(posedge clk);
            v = in_valid;
            #1;
            if (!rst_n) begin
                hist   = '0;
                last_z = '0;
            end else begin
                hist = {hist[0], v};
                chk("out_valid", {31'd0, out_valid}, {31'd0, hist[LAT-1]});
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        last_z = exp_q.pop_front();
                        chk("Z", Z, last_z);
                    end
                end else begin
                    chk("Z_hold", Z, last_z);
                end
            end
        end
    end

    initial begin
        logic [31:0] rx, ry;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        X        = '0;
        Y        = '0;
        #3;
        chk("reset_Z", Z, 32'h0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, hand-computed.
        drive(1, 32'hFFFFFFFF, 32'h00000010, 32'hFFFFFFFF);
        drive(0, 32'h0, 32'h0, 32'h0);
        drive(0, 32'h0, 32'h0, 32'h0);
        drive(1, 32'hAAAAAAAA, 32'h00000001, 32'hD5555555);
        drive(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive(1, 32'h7FFFFFFF, 32'h000000FF, 32'h00000000);
        drive(0, 32'h0, 32'h0, 32'h0);
        drive(1, 32'h80000000, 32'd31,       32'hFFFFFFFF);
        drive(1, 32'h12345678, 32'd0,        32'h12345678);
        drive(1, 32'h12345678, 32'd4,        32'h01234567);
        drive(1, 32'h80000000, 32'd32,       32'hFFFFFFFF);
        drive(1, 32'h40000000, 32'd32,       32'h00000000);
        drive(1, 32'h12345678, 32'd31,       32'h00000000);
        drive(1, 32'h87654321, 32'd8,        32'hFF876543);
        drive(1, 32'h87654321, 32'd16,       32'hFFFF8765);
        drive(1, 32'h7FFF0000, 32'h80000000, 32'h00000000);
        drive(0, 32'h0, 32'h0, 32'h0);
        drive(0, 32'h0, 32'h0, 32'h0);

        // Back-to-back random ops, Y mostly in 0..40.
        for (int i = 0; i < 100; i++) begin
            rx = $urandom;
            if ($urandom_range(0, 9) == 0) ry = $urandom;
            else                           ry = $urandom_range(0, 40);
            drive(1, rx, ry, ref_sra(rx, ry));
        end
        drive(0, 32'h0, 32'h0, 32'h0);
        repeat (LAT + 2) @(negedge clk);

        // Asynchronous reset between edges with an op in flight.
        drive(1, 32'hF0000000, 32'd4, 32'hFF000000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_Z", Z, 32'h0);
        chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        drive(1, 32'h80000001, 32'd1, 32'hC0000000);
        drive(0, 32'h0, 32'h0, 32'h0);
        repeat (LAT + 3) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
